// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serialises icache refills and dcache read/write traffic
// onto a single memory request port, one transaction outstanding at a time.
// Read responses are steered back to the granted requester; a read that gets
// no response within TIMEOUT_CYCLES is completed with zero data and flags err.
// Optional build macro ARB_RR_EN selects round-robin arbitration on ties;
// without it the dcache always wins ties.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_req_addr,
  output logic                i_resp_valid,
  output logic [DATA_W-1:0]   i_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic                d_req_rnw,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_data,
  input  logic [DATA_W/8-1:0] d_req_mask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_rnw,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_data,
  output logic [DATA_W/8-1:0] mem_req_mask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                busy,
  output logic                err
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                rnw_q, rnw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic                grant_dc_q, grant_dc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                pick_dc;
  logic                accept;
  logic                resp_hit;
  logic                timeout_hit;

  // Arbitration: who would win if a request were accepted this cycle
`ifdef ARB_RR_EN
  logic                last_dc_q, last_dc_d;
  assign pick_dc = d_req_valid & (~i_req_valid | ~last_dc_q);
`else
  assign pick_dc = d_req_valid;
`endif

  assign accept      = (state_q == ST_IDLE) & (i_req_valid | d_req_valid);
  assign resp_hit    = (state_q == ST_WAIT) & mem_resp_valid;
  assign timeout_hit = (state_q == ST_WAIT) & ~mem_resp_valid & (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ISSUE;
      ST_ISSUE: if (mem_req_ready) state_d = rnw_q ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (resp_hit || timeout_hit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Latched request fields, grant, timeout counter and sticky error
  always_comb begin
    rnw_d      = rnw_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    grant_dc_d = grant_dc_q;
    cnt_d      = cnt_q;
    err_d      = err_q | timeout_hit;
`ifdef ARB_RR_EN
    last_dc_d  = last_dc_q;
`endif
    if (accept) begin
      rnw_d      = pick_dc ? d_req_rnw  : 1'b1;
      addr_d     = pick_dc ? d_req_addr : i_req_addr;
      data_d     = pick_dc ? d_req_data : '0;
      mask_d     = pick_dc ? d_req_mask : '0;
      grant_dc_d = pick_dc;
`ifdef ARB_RR_EN
      last_dc_d  = pick_dc;
`endif
    end
    if ((state_q == ST_ISSUE) && mem_req_ready) begin
      cnt_d = '0;
    end else if ((state_q == ST_WAIT) && !mem_resp_valid && !timeout_hit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      grant_dc_q <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
`ifdef ARB_RR_EN
      last_dc_q  <= 1'b0;
`endif
    end else begin
      rnw_q      <= rnw_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      grant_dc_q <= grant_dc_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`ifdef ARB_RR_EN
      last_dc_q  <= last_dc_d;
`endif
    end
  end

  // Outputs: handshakes and response steering are combinational by design
  always_comb begin
    i_req_ready   = accept & ~pick_dc;
    d_req_ready   = accept & pick_dc;
    mem_req_valid = (state_q == ST_ISSUE);
    mem_req_rnw   = rnw_q;
    mem_req_addr  = addr_q;
    mem_req_data  = data_q;
    mem_req_mask  = mask_q;
    i_resp_valid  = (resp_hit | timeout_hit) & ~grant_dc_q;
    d_resp_valid  = (resp_hit | timeout_hit) & grant_dc_q;
    i_resp_data   = (resp_hit & ~grant_dc_q) ? mem_resp_data : '0;
    d_resp_data   = (resp_hit & grant_dc_q)  ? mem_resp_data : '0;
    busy          = (state_q != ST_IDLE);
    err           = err_q;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference.
module tb_cache_mem_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned TO     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_req_valid, i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic [DATA_W-1:0] i_resp_data;
  logic              d_req_valid, d_req_ready, d_req_rnw;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_req_data;
  logic [MASK_W-1:0] d_req_mask;
  logic              d_resp_valid;
  logic [DATA_W-1:0] d_resp_data;
  logic              mem_req_valid, mem_req_ready, mem_req_rnw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [MASK_W-1:0] mem_req_mask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              busy, err;

  always #5 clk = ~clk;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_rnw(d_req_rnw),
    .d_req_addr(d_req_addr), .d_req_data(d_req_data), .d_req_mask(d_req_mask),
    .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rnw(mem_req_rnw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_mask(mem_req_mask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one pending transaction, whether memory has taken it, and
  // how long the read has been waiting for data.
  typedef struct {
    logic              is_d;
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } txn_t;

  txn_t m_txn;
  bit   m_busy, m_sent, m_err, m_last_d;
  int   m_waited;

  int                i_pulses, d_pulses;
  logic [DATA_W-1:0] last_i_data, last_d_data;

  task automatic model_reset();
    m_txn    = '{is_d: 1'b0, rnw: 1'b0, addr: '0, data: '0, mask: '0};
    m_busy   = 0;
    m_sent   = 0;
    m_err    = 0;
    m_last_d = 0;
    m_waited = 0;
  endtask

  task automatic idle_inputs();
    i_req_valid    = 1'b0;
    i_req_addr     = '0;
    d_req_valid    = 1'b0;
    d_req_rnw      = 1'b0;
    d_req_addr     = '0;
    d_req_data     = '0;
    d_req_mask     = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // One clock: inputs are already set; check all outputs, advance reference.
  task automatic tick();
    bit any, win_d, rsp, tmo, exp_iv, exp_dv;
    #1;
    if (!rst_n) model_reset();
    any = !m_busy && (i_req_valid || d_req_valid);
`ifdef ARB_RR_EN
    win_d = d_req_valid && (!i_req_valid || !m_last_d);
`else
    win_d = d_req_valid;
`endif
    rsp    = m_busy && m_sent && mem_resp_valid;
    tmo    = m_busy && m_sent && !mem_resp_valid && (m_waited == TO - 1);
    exp_iv = (rsp || tmo) && !m_txn.is_d;
    exp_dv = (rsp || tmo) && m_txn.is_d;

    check("busy",          128'(busy),          128'(m_busy));
    check("err",           128'(err),           128'(m_err));
    check("i_req_ready",   128'(i_req_ready),   128'(any && !win_d));
    check("d_req_ready",   128'(d_req_ready),   128'(any && win_d));
    check("mem_req_valid", 128'(mem_req_valid), 128'(m_busy && !m_sent));
    check("mem_req_rnw",   128'(mem_req_rnw),   128'(m_txn.rnw));
    check("mem_req_addr",  128'(mem_req_addr),  128'(m_txn.addr));
    check("mem_req_data",  128'(mem_req_data),  128'(m_txn.data));
    check("mem_req_mask",  128'(mem_req_mask),  128'(m_txn.mask));
    check("i_resp_valid",  128'(i_resp_valid),  128'(exp_iv));
    check("d_resp_valid",  128'(d_resp_valid),  128'(exp_dv));
    if (exp_iv) check("i_resp_data", 128'(i_resp_data), tmo ? 128'(0) : 128'(mem_resp_data));
    if (exp_dv) check("d_resp_data", 128'(d_resp_data), tmo ? 128'(0) : 128'(mem_resp_data));

    if (i_resp_valid) begin i_pulses++; last_i_data = i_resp_data; end
    if (d_resp_valid) begin d_pulses++; last_d_data = d_resp_data; end

    if (rst_n) begin
      if (!m_busy) begin
        if (any) begin
          m_busy      = 1;
          m_sent      = 0;
          m_txn.is_d  = win_d;
          m_txn.rnw   = win_d ? d_req_rnw  : 1'b1;
          m_txn.addr  = win_d ? d_req_addr : i_req_addr;
          m_txn.data  = win_d ? d_req_data : '0;
          m_txn.mask  = win_d ? d_req_mask : '0;
          m_last_d    = win_d;
        end
      end else if (!m_sent) begin
        if (mem_req_ready) begin
          if (m_txn.rnw) begin
            m_sent   = 1;
            m_waited = 0;
          end else begin
            m_busy = 0;
          end
        end
      end else if (rsp || tmo) begin
        m_busy = 0;
        m_sent = 0;
        if (tmo) m_err = 1;
      end else begin
        m_waited++;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    i_pulses = 0;
    d_pulses = 0;
    last_i_data = '0;
    last_d_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_gnt_d [4];
    int waits;
    bit resp_mode;

    idle_inputs();
    model_reset();
    clear_pulses();
    rst_n = 1'b0;
    @(negedge clk);
    tick();
    check("rst_busy",      128'(busy),          128'(0));
    check("rst_err",       128'(err),           128'(0));
    check("rst_mem_valid", 128'(mem_req_valid), 128'(0));
    rst_n = 1'b1;
    tick();

    // Icache read, response on the third cycle after accept
    clear_pulses();
    i_req_valid = 1'b1; i_req_addr = 32'h1000; mem_req_ready = 1'b1;
    #1;
    check("ic_ready", 128'(i_req_ready), 128'(1));
    tick();
    i_req_valid = 1'b0; i_req_addr = '0;
    check("ic_mem_valid", 128'(mem_req_valid), 128'(1));
    check("ic_mem_addr",  128'(mem_req_addr),  128'(32'h1000));
    check("ic_mem_rnw",   128'(mem_req_rnw),   128'(1));
    tick();
    mem_req_ready = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 128'hDEADBEEF;
    tick();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    tick();
    check("ic_i_pulses", 128'(i_pulses),    128'(1));
    check("ic_i_data",   128'(last_i_data), 128'(32'hDEADBEEF));
    check("ic_d_pulses", 128'(d_pulses),    128'(0));

    // Dcache write held off by memory for 4 cycles
    clear_pulses();
    d_req_valid = 1'b1; d_req_rnw = 1'b0; d_req_addr = 32'h2000;
    d_req_data = 128'h1234; d_req_mask = 16'hFFFF; mem_req_ready = 1'b0;
    tick();
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      check("dw_valid", 128'(mem_req_valid), 128'(1));
      check("dw_rnw",   128'(mem_req_rnw),   128'(0));
      check("dw_addr",  128'(mem_req_addr),  128'(32'h2000));
      check("dw_data",  128'(mem_req_data),  128'(16'h1234));
      check("dw_mask",  128'(mem_req_mask),  128'(16'hFFFF));
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("dw_idle_after", 128'(busy), 128'(0));
    tick();
    check("dw_i_pulses", 128'(i_pulses), 128'(0));
    check("dw_d_pulses", 128'(d_pulses), 128'(0));

    // Simultaneous reads, four rounds, from a fresh reset
`ifdef ARB_RR_EN
    exp_gnt_d = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_gnt_d = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    for (int k = 0; k < 4; k++) begin
      i_req_valid = 1'b1; i_req_addr = 32'h100 + 32'(k);
      d_req_valid = 1'b1; d_req_rnw = 1'b1; d_req_addr = 32'h200 + 32'(k);
      mem_req_ready = 1'b1;
      #1;
      check("arb_d_grant", 128'(d_req_ready), 128'(exp_gnt_d[k]));
      check("arb_i_grant", 128'(i_req_ready), 128'(!exp_gnt_d[k]));
      tick();
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      tick();
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      mem_resp_valid = 1'b0;
    end
    tick();

    // Read timeout
    clear_pulses();
    d_req_valid = 1'b1; d_req_rnw = 1'b1; d_req_addr = 32'h3000; mem_req_ready = 1'b1;
    tick();
    idle_inputs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    waits = 0;
    while (busy && waits < 40) begin
      tick();
      waits++;
    end
    check("to_wait_cycles", 128'(waits),       128'(TO));
    check("to_d_pulses",    128'(d_pulses),    128'(1));
    check("to_d_data",      128'(last_d_data), 128'(0));
    check("to_i_pulses",    128'(i_pulses),    128'(0));
    check("to_err",         128'(err),         128'(1));
    check("to_idle",        128'(busy),        128'(0));
    i_req_valid = 1'b1; i_req_addr = 32'h4000; mem_req_ready = 1'b1;
    tick();
    i_req_valid = 1'b0;
    tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 128'h55;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    check("to_err_sticky", 128'(err), 128'(1));

    // Reset while waiting for read data
    i_req_valid = 1'b1; i_req_addr = 32'h5000; mem_req_ready = 1'b1;
    tick();
    idle_inputs();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tick();
    check("rw_in_wait", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("rw_busy",      128'(busy),          128'(0));
    check("rw_err",       128'(err),           128'(0));
    check("rw_mem_valid", 128'(mem_req_valid), 128'(0));
    check("rw_mem_addr",  128'(mem_req_addr),  128'(0));
    check("rw_i_resp",    128'(i_resp_valid),  128'(0));
    check("rw_d_resp",    128'(d_resp_valid),  128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    clear_pulses();
    mem_resp_valid = 1'b1; mem_resp_data = 128'hABCD;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    check("rw_no_i_resp", 128'(i_pulses), 128'(0));
    check("rw_no_d_resp", 128'(d_pulses), 128'(0));

    // Stray response while idle
    mem_resp_valid = 1'b1; mem_resp_data = 128'h77;
    #1;
    check("stray_i", 128'(i_resp_valid), 128'(0));
    check("stray_d", 128'(d_resp_valid), 128'(0));
    tick();
    mem_resp_valid = 1'b0;
    check("stray_idle", 128'(busy), 128'(0));
    tick();

    // Randomized traffic against the reference
    resp_mode = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 0) resp_mode = 1'($urandom_range(0, 1));
      i_req_valid    = 1'($urandom_range(0, 1));
      i_req_addr     = $urandom();
      d_req_valid    = 1'($urandom_range(0, 1));
      d_req_rnw      = 1'($urandom_range(0, 1));
      d_req_addr     = $urandom();
      d_req_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
      d_req_mask     = 16'($urandom());
      mem_req_ready  = 1'($urandom_range(0, 1));
      mem_resp_valid = resp_mode ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      mem_resp_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
